fxp_result_buffer: RTL and testbench



---
 rtl/fxp_result_buffer_pkg.sv | 23 ++
 rtl/fxp_result_buffer_if.sv | 27 ++
 rtl/fxp_result_buffer_fifo_mem.sv | 20 ++
 rtl/fxp_result_buffer.sv | 107 ++++++++++
 tb/tb_fxp_result_buffer.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/fxp_result_buffer_pkg.sv
// rtl/fxp_result_buffer_pkg.sv - shared types, defaults and helper functions for the result buffer
package fxp_result_buffer_pkg;

  localparam int IN_W  = 32;
  localparam int OUT_W = 24;
  localparam int SHIFT = 6;
  localparam int DEPTH = 8;

  typedef logic signed [OUT_W-1:0] outWord_t;

  function automatic longint satMax(int outW);
    return (longint'(1) << (outW - 1)) - 1;
  endfunction

  function automatic longint satMin(int outW);
    return -(longint'(1) << (outW - 1));
  endfunction

  function automatic int levelWidth(int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fxp_result_buffer_if.sv
// rtl/fxp_result_buffer_if.sv - filter strobe input, narrowed output stream and status
interface fxp_result_buffer_if
  import fxp_result_buffer_pkg::*;
#(
  parameter int IN_W  = fxp_result_buffer_pkg::IN_W,
  parameter int OUT_W = fxp_result_buffer_pkg::OUT_W,
  parameter int DEPTH = fxp_result_buffer_pkg::DEPTH
);
  logic [IN_W-1:0]              in_data;
  logic                         in_valid;
  logic [OUT_W-1:0]             out_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [levelWidth(DEPTH)-1:0] level;
  logic                         sat_flag;
  logic                         overflow;

  modport master (
    output in_data, in_valid, out_ready,
    input  out_data, out_valid, level, sat_flag, overflow
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output out_data, out_valid, level, sat_flag, overflow
  );
endinterface

// File: rtl/fxp_result_buffer_fifo_mem.sv
// rtl/fxp_result_buffer_fifo_mem.sv - DEPTH x W register array, one write port, async read
module fxp_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int W     = 24
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/fxp_result_buffer.sv
// rtl/fxp_result_buffer.sv - narrow (shift+saturate) filter results and queue them on a valid/ready stream
// Optional build macro RESULT_ROUND_EN: round-half-up before the shift instead of floor.
module fxp_result_buffer
  import fxp_result_buffer_pkg::*;
#(
  parameter int IN_W  = fxp_result_buffer_pkg::IN_W,
  parameter int OUT_W = fxp_result_buffer_pkg::OUT_W,
  parameter int SHIFT = fxp_result_buffer_pkg::SHIFT,
  parameter int DEPTH = fxp_result_buffer_pkg::DEPTH
) (
  input logic clk,
  input logic rst,
  fxp_result_buffer_if.slave bus
);
  localparam int LW = levelWidth(DEPTH);
  localparam int PW = $clog2(DEPTH);
  localparam logic signed [IN_W:0] MAX_V = (IN_W+1)'(satMax(OUT_W));
  localparam logic signed [IN_W:0] MIN_V = (IN_W+1)'(satMin(OUT_W));
`ifdef RESULT_ROUND_EN
  localparam logic signed [IN_W:0] BIAS = (IN_W+1)'((longint'(1) << SHIFT) >> 1);
`endif

  logic signed [IN_W:0] extIn, biased, shifted;
  logic                 sat;
  logic [OUT_W-1:0]     narrow;

  logic                 stgValid;
  logic [OUT_W-1:0]     stgWord;
  logic [PW-1:0]        wrPtr, rdPtr, rdNext;
  logic [LW-1:0]        levelQ, levelNext;
  logic                 push, pop;
  logic [OUT_W-1:0]     memRdata, headNext, outDataQ;
  logic                 outValidQ, satFlagQ, overflowQ;

  // One extra bit of headroom so rounding and the saturation compare never wrap.
  always_comb begin
    extIn = {bus.in_data[IN_W-1], bus.in_data};
`ifdef RESULT_ROUND_EN
    biased = extIn + BIAS;
`else
    biased = extIn;
`endif
    shifted = biased >>> SHIFT;
    sat     = 1'b0;
    narrow  = shifted[OUT_W-1:0];
    if (shifted > MAX_V) begin
      sat    = 1'b1;
      narrow = MAX_V[OUT_W-1:0];
    end else if (shifted < MIN_V) begin
      sat    = 1'b1;
      narrow = MIN_V[OUT_W-1:0];
    end
  end

  assign pop  = outValidQ && bus.out_ready;
  assign push = stgValid && ((levelQ != LW'(DEPTH)) || pop);

  always_comb begin
    rdNext    = pop ? rdPtr + PW'(1) : rdPtr;
    levelNext = levelQ;
    if (push && !pop) levelNext = levelQ + LW'(1);
    if (pop && !push) levelNext = levelQ - LW'(1);
    // A word written into the slot that becomes the head bypasses the array.
    headNext  = (push && (wrPtr == rdNext)) ? stgWord : memRdata;
  end

  fxp_fifo_mem #(.DEPTH(DEPTH), .W(OUT_W)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wrPtr),
    .wdata (stgWord),
    .raddr (rdNext),
    .rdata (memRdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      stgValid  <= 1'b0;
      stgWord   <= '0;
      wrPtr     <= '0;
      rdPtr     <= '0;
      levelQ    <= '0;
      outDataQ  <= '0;
      outValidQ <= 1'b0;
      satFlagQ  <= 1'b0;
      overflowQ <= 1'b0;
    end else begin
      stgValid <= bus.in_valid;
      if (bus.in_valid) begin
        stgWord <= narrow;
        if (sat) satFlagQ <= 1'b1;
      end
      if (stgValid && !push) overflowQ <= 1'b1;
      if (push) wrPtr <= wrPtr + PW'(1);
      rdPtr     <= rdNext;
      levelQ    <= levelNext;
      outValidQ <= (levelNext != '0);
      if (levelNext != '0) outDataQ <= headNext;
    end
  end

  assign bus.out_data  = outDataQ;
  assign bus.out_valid = outValidQ;
  assign bus.level     = levelQ;
  assign bus.sat_flag  = satFlagQ;
  assign bus.overflow  = overflowQ;
endmodule

// File: tb/tb_fxp_result_buffer.sv
// tb/tb_fxp_result_buffer.sv - directed checks of narrowing, saturation, FIFO flow control and reset
module tb_fxp_result_buffer;
  import fxp_result_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] expPos, expNeg;

  fxp_result_buffer_if bus();

  fxp_result_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef RESULT_ROUND_EN
    expPos = 32'h000013;
    expNeg = 32'hFFFFEE;
`else
    expPos = 32'h000012;
    expNeg = 32'hFFFFED;
`endif
    rst = 1'b0;
    bus.in_data = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    tick(3);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_level", 32'(bus.level), 32'd0);
    check("rst_sat", 32'(bus.sat_flag), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    rst = 1'b1;
    tick(1);

    // positive word, latency and pop
    bus.out_ready = 1'b1;
    bus.in_data = 32'h000004A0;
    bus.in_valid = 1'b1;
    tick(1);
    bus.in_valid = 1'b0;
    check("pos_lat1_valid", 32'(bus.out_valid), 32'd0);
    tick(1);
    check("pos_lat2_valid", 32'(bus.out_valid), 32'd1);
    check("pos_data", 32'(bus.out_data), expPos);
    tick(1);
    check("pos_popped_valid", 32'(bus.out_valid), 32'd0);
    check("pos_hold_data", 32'(bus.out_data), expPos);
    check("pos_popped_level", 32'(bus.level), 32'd0);

    // negative word
    bus.in_data = 32'hFFFFFB60;
    bus.in_valid = 1'b1;
    tick(1);
    bus.in_valid = 1'b0;
    tick(1);
    check("neg_valid", 32'(bus.out_valid), 32'd1);
    check("neg_data", 32'(bus.out_data), expNeg);
    check("neg_sat", 32'(bus.sat_flag), 32'd0);
    tick(2);

    // saturation, back-to-back strobes
    bus.in_data = 32'h7FFFFFFF;
    bus.in_valid = 1'b1;
    tick(1);
    bus.in_data = 32'h80000000;
    tick(1);
    bus.in_valid = 1'b0;
    check("satp_data", 32'(bus.out_data), 32'h7FFFFF);
    check("satp_flag", 32'(bus.sat_flag), 32'd1);
    tick(1);
    check("satn_data", 32'(bus.out_data), 32'h800000);
    check("satn_level", 32'(bus.level), 32'd1);
    tick(2);
    check("sat_drained", 32'(bus.level), 32'd0);

    // back-pressure: 10 strobes, only 8 fit
    bus.out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      bus.in_data = 32'((k + 1) << 6);
      bus.in_valid = 1'b1;
      tick(1);
      bus.in_valid = 1'b0;
      tick(11);
    end
    check("bp_level", 32'(bus.level), 32'd8);
    check("bp_ovf", 32'(bus.overflow), 32'd1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("bp_valid%0d", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("bp_data%0d", i), 32'(bus.out_data), 32'(i + 1));
      tick(1);
    end
    check("bp_empty_valid", 32'(bus.out_valid), 32'd0);
    check("bp_empty_level", 32'(bus.level), 32'd0);

    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    check("rst2_ovf", 32'(bus.overflow), 32'd0);
    tick(1);

    // full FIFO with simultaneous pop
    bus.out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus.in_data = 32'((k + 16) << 6);
      bus.in_valid = 1'b1;
      tick(1);
    end
    bus.in_valid = 1'b0;
    tick(2);
    check("full_level", 32'(bus.level), 32'd8);
    bus.in_data = 32'(24 << 6);
    bus.in_valid = 1'b1;
    tick(1);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick(1);
    bus.out_ready = 1'b0;
    check("fullpop_level", 32'(bus.level), 32'd8);
    check("fullpop_ovf", 32'(bus.overflow), 32'd0);
    check("fullpop_head", 32'(bus.out_data), 32'h11);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("fp_data%0d", i), 32'(bus.out_data), 32'(17 + i));
      tick(1);
    end
    check("fp_empty", 32'(bus.out_valid), 32'd0);

    // reset mid-stream with level 5 and a word in the narrowing stage
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.in_data = 32'((k + 32) << 6);
      bus.in_valid = 1'b1;
      tick(1);
    end
    bus.in_valid = 1'b0;
    tick(2);
    check("mid_level5", 32'(bus.level), 32'd5);
    bus.in_data = 32'h7FFFFFFF;
    bus.in_valid = 1'b1;
    tick(1);
    bus.in_valid = 1'b0;
    check("mid_sat_set", 32'(bus.sat_flag), 32'd1);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    check("mid_level", 32'(bus.level), 32'd0);
    check("mid_valid", 32'(bus.out_valid), 32'd0);
    check("mid_data", 32'(bus.out_data), 32'd0);
    check("mid_sat", 32'(bus.sat_flag), 32'd0);
    check("mid_ovf", 32'(bus.overflow), 32'd0);
    tick(3);
    check("mid_no_stale_valid", 32'(bus.out_valid), 32'd0);
    check("mid_no_stale_level", 32'(bus.level), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
